// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared encodings for the two-master memory port arbiter.
package cpu_bus_arbiter_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 8;
  localparam int unsigned DEF_ADDR_WIDTH  = 24;
  localparam int unsigned DEF_WAIT_STATES = 1;

  localparam logic WHICH_READ  = 1'b0;
  localparam logic WHICH_WRITE = 1'b1;

  localparam logic REQ_IDX_R0 = 1'b0;
  localparam logic REQ_IDX_R1 = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } arb_state_e;

  // Wait counter must hold WAIT_STATES without truncation and is never zero-width.
  function automatic int unsigned cnt_width(input int unsigned ws);
    return (ws < 1) ? 1 : $clog2(ws + 1);
  endfunction

endpackage

// File: rtl/cpu_bus_arbiter_if.sv
// Bundle of both requester channels and the shared memory port.
interface cpu_bus_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 24
);

  logic                  r0_req;
  logic                  r0_which;
  logic [ADDR_WIDTH-1:0] r0_addr;
  logic [DATA_WIDTH-1:0] r0_wdata;
  logic [DATA_WIDTH-1:0] r0_rdata;
  logic                  r0_ack;

  logic                  r1_req;
  logic                  r1_which;
  logic [ADDR_WIDTH-1:0] r1_addr;
  logic [DATA_WIDTH-1:0] r1_wdata;
  logic [DATA_WIDTH-1:0] r1_rdata;
  logic                  r1_ack;

  logic                  mem_req;
  logic                  mem_which;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  r0_req, r0_which, r0_addr, r0_wdata,
    output r0_rdata, r0_ack,
    input  r1_req, r1_which, r1_addr, r1_wdata,
    output r1_rdata, r1_ack,
    output mem_req, mem_which, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requester and memory side.
  modport master (
    output r0_req, r0_which, r0_addr, r0_wdata,
    input  r0_rdata, r0_ack,
    output r1_req, r1_which, r1_addr, r1_wdata,
    input  r1_rdata, r1_ack,
    input  mem_req, mem_which, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/cpu_bus_arbiter_bus_rr_pick.sv
// Two-way round-robin selector: on a tie, the requester not granted last wins.
module bus_rr_pick
  import cpu_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid_c,
  output logic       gnt_idx_c
);

  always_comb begin
    gnt_valid_c = |req;
    gnt_idx_c   = REQ_IDX_R0;
    if (req == 2'b11) begin
      gnt_idx_c = ~last_gnt;
    end else if (req[1]) begin
      gnt_idx_c = REQ_IDX_R1;
    end
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between two masters.
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic               clk,
  input  logic               rst,
  cpu_bus_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W = cnt_width(WAIT_STATES);

  arb_state_e            state_q, state_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                  last_q, last_d;
  logic                  gnt_idx_q, gnt_idx_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_which_q, mem_which_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  r0_ack_q, r0_ack_d;
  logic                  r1_ack_q, r1_ack_d;
  logic [DATA_WIDTH-1:0] r0_rdata_q, r0_rdata_d;
  logic [DATA_WIDTH-1:0] r1_rdata_q, r1_rdata_d;

  logic gnt_valid_c;
  logic gnt_idx_c;

  bus_rr_pick u_pick (
    .req         ({bus.r1_req, bus.r0_req}),
    .last_gnt    (last_q),
    .gnt_valid_c (gnt_valid_c),
    .gnt_idx_c   (gnt_idx_c)
  );

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    last_d      = last_q;
    gnt_idx_d   = gnt_idx_q;
    mem_req_d   = mem_req_q;
    mem_which_d = mem_which_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    r0_ack_d    = 1'b0;
    r1_ack_d    = 1'b0;
    r0_rdata_d  = r0_rdata_q;
    r1_rdata_d  = r1_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid_c) begin
          state_d    = ST_ACCESS;
          mem_req_d  = 1'b1;
          gnt_idx_d  = gnt_idx_c;
          wait_cnt_d = CNT_W'(WAIT_STATES);
          if (gnt_idx_c == REQ_IDX_R1) begin
            mem_which_d = bus.r1_which;
            mem_addr_d  = bus.r1_addr;
            mem_wdata_d = bus.r1_wdata;
          end else begin
            mem_which_d = bus.r0_which;
            mem_addr_d  = bus.r0_addr;
            mem_wdata_d = bus.r0_wdata;
          end
        end
      end

      ST_ACCESS: begin
        if (wait_cnt_q != '0) begin
          wait_cnt_d = wait_cnt_q - CNT_W'(1);
        end else begin
          // Final memory cycle: mem_rdata is valid now.
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          last_d    = gnt_idx_q;
          if (gnt_idx_q == REQ_IDX_R1) begin
            r1_ack_d = 1'b1;
            if (mem_which_q == WHICH_READ) r1_rdata_d = bus.mem_rdata;
          end else begin
            r0_ack_d = 1'b1;
            if (mem_which_q == WHICH_READ) r0_rdata_d = bus.mem_rdata;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      last_q      <= REQ_IDX_R1;
      gnt_idx_q   <= REQ_IDX_R0;
      mem_req_q   <= 1'b0;
      mem_which_q <= WHICH_READ;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      r0_ack_q    <= 1'b0;
      r1_ack_q    <= 1'b0;
      r0_rdata_q  <= '0;
      r1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      last_q      <= last_d;
      gnt_idx_q   <= gnt_idx_d;
      mem_req_q   <= mem_req_d;
      mem_which_q <= mem_which_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      r0_ack_q    <= r0_ack_d;
      r1_ack_q    <= r1_ack_d;
      r0_rdata_q  <= r0_rdata_d;
      r1_rdata_q  <= r1_rdata_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_which = mem_which_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.r0_ack    = r0_ack_q;
  assign bus.r1_ack    = r1_ack_q;
  assign bus.r0_rdata  = r0_rdata_q;
  assign bus.r1_rdata  = r1_rdata_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter with WAIT_STATES of 1, 0 and 15.
module tb_cpu_bus_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  cpu_bus_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(24)) bus1 ();
  cpu_bus_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(24)) bus0 ();
  cpu_bus_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(24)) bus15 ();

  cpu_bus_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(24), .WAIT_STATES(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  cpu_bus_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(24), .WAIT_STATES(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  cpu_bus_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(24), .WAIT_STATES(15))
    dut15 (.clk(clk), .rst(rst), .bus(bus15.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    {bus1.r0_req, bus1.r0_which, bus1.r0_addr, bus1.r0_wdata} = '0;
    {bus1.r1_req, bus1.r1_which, bus1.r1_addr, bus1.r1_wdata} = '0;
    {bus0.r0_req, bus0.r0_which, bus0.r0_addr, bus0.r0_wdata} = '0;
    {bus0.r1_req, bus0.r1_which, bus0.r1_addr, bus0.r1_wdata} = '0;
    {bus15.r0_req, bus15.r0_which, bus15.r0_addr, bus15.r0_wdata} = '0;
    {bus15.r1_req, bus15.r1_which, bus15.r1_addr, bus15.r1_wdata} = '0;
    bus1.mem_rdata  = 8'h00;
    bus0.mem_rdata  = 8'h00;
    bus15.mem_rdata = 8'h00;
    tick();
    tick();

    // Reset values.
    check("rst_mem_req",   64'(bus1.mem_req),   64'h0);
    check("rst_mem_which", 64'(bus1.mem_which), 64'h0);
    check("rst_mem_addr",  64'(bus1.mem_addr),  64'h0);
    check("rst_mem_wdata", 64'(bus1.mem_wdata), 64'h0);
    check("rst_acks",      64'({bus1.r0_ack, bus1.r1_ack}), 64'h0);
    check("rst_rdata",     64'({bus1.r0_rdata, bus1.r1_rdata}), 64'h0);
    rst = 1'b0;

    // Single r0 read, WAIT_STATES=1.
    bus1.r0_req = 1'b1; bus1.r0_which = 1'b0; bus1.r0_addr = 24'h001234;
    bus1.mem_rdata = 8'hA5;
    tick();
    check("rd_c1_mem_req", 64'(bus1.mem_req), 64'h1);
    check("rd_c1_addr",    64'(bus1.mem_addr), 64'h001234);
    check("rd_c1_which",   64'(bus1.mem_which), 64'h0);
    check("rd_c1_acks",    64'({bus1.r0_ack, bus1.r1_ack}), 64'h0);
    tick();
    check("rd_c2_mem_req", 64'(bus1.mem_req), 64'h1);
    check("rd_c2_acks",    64'({bus1.r0_ack, bus1.r1_ack}), 64'h0);
    tick();
    check("rd_c3_mem_req", 64'(bus1.mem_req), 64'h0);
    check("rd_c3_r0_ack",  64'(bus1.r0_ack), 64'h1);
    check("rd_c3_r1_ack",  64'(bus1.r1_ack), 64'h0);
    check("rd_c3_rdata",   64'(bus1.r0_rdata), 64'hA5);
    bus1.r0_req = 1'b0;
    bus1.mem_rdata = 8'h00;
    tick();
    check("rd_c4_acks",    64'({bus1.r0_ack, bus1.r1_ack}), 64'h0);
    check("rd_c4_mem_req", 64'(bus1.mem_req), 64'h0);
    check("rd_c4_rdata",   64'(bus1.r0_rdata), 64'hA5);

    // r1 write; mem_rdata is noise that must not be captured.
    bus1.r1_req = 1'b1; bus1.r1_which = 1'b1; bus1.r1_addr = 24'h7E0010;
    bus1.r1_wdata = 8'h3C; bus1.mem_rdata = 8'hFF;
    for (int c = 1; c <= 2; c++) begin
      tick();
      check($sformatf("wr_c%0d_mem_req", c), 64'(bus1.mem_req), 64'h1);
      check($sformatf("wr_c%0d_which", c),   64'(bus1.mem_which), 64'h1);
      check($sformatf("wr_c%0d_addr", c),    64'(bus1.mem_addr), 64'h7E0010);
      check($sformatf("wr_c%0d_wdata", c),   64'(bus1.mem_wdata), 64'h3C);
      check($sformatf("wr_c%0d_acks", c),    64'({bus1.r0_ack, bus1.r1_ack}), 64'h0);
    end
    tick();
    check("wr_c3_acks",    64'({bus1.r0_ack, bus1.r1_ack}), 64'h1);
    check("wr_c3_mem_req", 64'(bus1.mem_req), 64'h0);
    check("wr_c3_r1_rdata", 64'(bus1.r1_rdata), 64'h00);
    bus1.r1_req = 1'b0; bus1.r1_which = 1'b0;
    tick();
    check("wr_c4_acks",    64'({bus1.r0_ack, bus1.r1_ack}), 64'h0);

    // Continuous contention from reset: r0 wins the first tie, then alternate.
    rst = 1'b1;
    bus1.r0_req = 1'b1; bus1.r0_which = 1'b0; bus1.r0_addr = 24'h000100;
    bus1.r1_req = 1'b1; bus1.r1_which = 1'b0; bus1.r1_addr = 24'h000200;
    bus1.mem_rdata = 8'h11;
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      check($sformatf("rr_c%0d_mem_req", c), 64'(bus1.mem_req), 64'((c % 3) != 0));
      check($sformatf("rr_c%0d_r0_ack", c),  64'(bus1.r0_ack), 64'(c == 3 || c == 9));
      check($sformatf("rr_c%0d_r1_ack", c),  64'(bus1.r1_ack), 64'(c == 6 || c == 12));
      check($sformatf("rr_c%0d_overlap", c),
            64'((bus1.r0_ack & bus1.r1_ack) | (bus1.mem_req & (bus1.r0_ack | bus1.r1_ack))), 64'h0);
      if ((c % 3) != 0)
        check($sformatf("rr_c%0d_addr", c), 64'(bus1.mem_addr),
              (((c - 1) / 3) % 2 == 0) ? 64'h000100 : 64'h000200);
      if (c == 3) check("rr_c3_r0_rdata", 64'(bus1.r0_rdata), 64'h11);
    end
    bus1.r0_req = 1'b0; bus1.r1_req = 1'b0;
    tick();
    check("rr_end_mem_req", 64'(bus1.mem_req), 64'h0);

    // Reset in the second mem_req cycle aborts; a fresh request then completes.
    bus1.r0_req = 1'b1; bus1.r0_addr = 24'h00ABCD; bus1.mem_rdata = 8'h5A;
    tick();
    check("ab_c1_mem_req", 64'(bus1.mem_req), 64'h1);
    tick();
    check("ab_c2_mem_req", 64'(bus1.mem_req), 64'h1);
    rst = 1'b1;
    tick();
    check("ab_c3_mem", 64'({bus1.mem_req, bus1.mem_which, bus1.mem_addr, bus1.mem_wdata}), 64'h0);
    check("ab_c3_acks", 64'({bus1.r0_ack, bus1.r1_ack}), 64'h0);
    check("ab_c3_rdata", 64'({bus1.r0_rdata, bus1.r1_rdata}), 64'h0);
    rst = 1'b0;
    tick();
    check("ab_c4_mem_req", 64'(bus1.mem_req), 64'h1);
    check("ab_c4_acks", 64'({bus1.r0_ack, bus1.r1_ack}), 64'h0);
    tick();
    check("ab_c5_mem_req", 64'(bus1.mem_req), 64'h1);
    tick();
    check("ab_c6_r0_ack", 64'(bus1.r0_ack), 64'h1);
    check("ab_c6_rdata",  64'(bus1.r0_rdata), 64'h5A);
    bus1.r0_req = 1'b0;
    tick();

    // r0 drops req mid-access; pending r1 is granted next.
    bus1.r0_req = 1'b1; bus1.r0_addr = 24'h000010; bus1.mem_rdata = 8'h77;
    tick();
    check("dr_c1_addr", 64'(bus1.mem_addr), 64'h000010);
    bus1.r0_req = 1'b0;
    bus1.r1_req = 1'b1; bus1.r1_addr = 24'h000020;
    tick();
    check("dr_c2_mem_req", 64'(bus1.mem_req), 64'h1);
    tick();
    check("dr_c3_acks",  64'({bus1.r0_ack, bus1.r1_ack}), 64'h2);
    check("dr_c3_rdata", 64'(bus1.r0_rdata), 64'h77);
    tick();
    bus1.mem_rdata = 8'h88;
    check("dr_c4_mem_req", 64'(bus1.mem_req), 64'h1);
    check("dr_c4_addr",    64'(bus1.mem_addr), 64'h000020);
    tick();
    check("dr_c5_mem_req", 64'(bus1.mem_req), 64'h1);
    tick();
    check("dr_c6_acks",  64'({bus1.r0_ack, bus1.r1_ack}), 64'h1);
    check("dr_c6_rdata", 64'(bus1.r1_rdata), 64'h88);
    bus1.r1_req = 1'b0;
    tick();

    // WAIT_STATES=0: one mem_req cycle, ack latency 2.
    bus0.r0_req = 1'b1; bus0.r0_addr = 24'h000042; bus0.mem_rdata = 8'h99;
    tick();
    check("w0_c1_mem_req", 64'(bus0.mem_req), 64'h1);
    check("w0_c1_ack",     64'(bus0.r0_ack), 64'h0);
    tick();
    check("w0_c2_mem_req", 64'(bus0.mem_req), 64'h0);
    check("w0_c2_ack",     64'(bus0.r0_ack), 64'h1);
    check("w0_c2_rdata",   64'(bus0.r0_rdata), 64'h99);
    bus0.r0_req = 1'b0;
    tick();
    check("w0_c3_ack",     64'(bus0.r0_ack), 64'h0);

    // WAIT_STATES=15: sixteen mem_req cycles, ack latency 17.
    bus15.r1_req = 1'b1; bus15.r1_addr = 24'hFFFFFF; bus15.mem_rdata = 8'hC3;
    for (int c = 1; c <= 16; c++) begin
      tick();
      check($sformatf("w15_c%0d_mem_req", c), 64'(bus15.mem_req), 64'h1);
      check($sformatf("w15_c%0d_acks", c), 64'({bus15.r0_ack, bus15.r1_ack}), 64'h0);
    end
    tick();
    check("w15_c17_mem_req", 64'(bus15.mem_req), 64'h0);
    check("w15_c17_acks",    64'({bus15.r0_ack, bus15.r1_ack}), 64'h1);
    check("w15_c17_rdata",   64'(bus15.r1_rdata), 64'hC3);
    bus15.r1_req = 1'b0;
    tick();
    check("w15_c18_acks",    64'({bus15.r0_ack, bus15.r1_ack}), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
